// File: rtl/lcd_write_sequencer.sv
// -----------------------------------------------------------------------------
// lcd_write_sequencer
//
// Purpose:
//   Turns CPU stores to the LCD register into properly timed HD44780 bus
//   cycles. Each store arrives as a one-cycle strobe plus the stored word.
//   Commands are queued in a small FIFO and replayed one at a time with
//   setup, enable-pulse, hold and execution delays. Software therefore never
//   toggles EN itself and only needs the status flags for flow control.
//
// Ports:
//   i_clk        system clock
//   i_rst_n      asynchronous, active-low reset
//   i_wr         one-cycle store strobe from the output bank
//   i_wdata      stored word: [31]=ON, [30]=CTRL_ONLY, [9]=RS, [7:0]=DATA
//   i_clr_ovf    clears o_overflow (a same-edge overflow wins)
//   o_lcd_data   LCD DB[7:0]
//   o_lcd_rs     LCD register select
//   o_lcd_rw     LCD read/write, tied to write (0)
//   o_lcd_en     LCD enable strobe
//   o_lcd_on     LCD power/backlight enable
//   o_busy       queue non-empty or sequencer not idle
//   o_full       queue holds FIFO_DEPTH entries
//   o_overflow   sticky: a command write was dropped
// -----------------------------------------------------------------------------
module lcd_write_sequencer #(
    parameter int FIFO_DEPTH  = 4,
    parameter int T_SETUP     = 2,
    parameter int T_PULSE     = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 1850,
    parameter int T_EXEC_LONG = 76000
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wr,
    input  logic [31:0] i_wdata,
    input  logic        i_clr_ovf,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_busy,
    output logic        o_full,
    output logic        o_overflow
);

    // Counter must hold the largest reload value of any phase.
    localparam int MAX_A   = (T_EXEC_LONG > T_EXEC)  ? T_EXEC_LONG : T_EXEC;
    localparam int MAX_B   = (T_PULSE > T_SETUP)     ? T_PULSE     : T_SETUP;
    localparam int MAX_C   = (MAX_B > T_HOLD)        ? MAX_B       : T_HOLD;
    localparam int CNT_MAX = (MAX_A > MAX_C)         ? MAX_A       : MAX_C;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int OCC_W   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_EXEC
    } state_t;

    // Queue storage: {RS, DATA}
    logic [8:0]       mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [OCC_W-1:0] occ;
    logic [OCC_W-1:0] occ_next;

    state_t           state;
    logic [CNT_W-1:0] cnt;

    logic             cmd_wr;
    logic             q_full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [8:0]       head;
    logic             fsm_idle_next;
    logic             is_long;
    logic [CNT_W-1:0] exec_load;

    // Bits of the stored word that carry no meaning for this block.
    logic             unused_wdata;
    assign unused_wdata = ^{i_wdata[29:10], i_wdata[8]};

    assign o_lcd_rw = 1'b0;

    // CTRL_ONLY writes only touch the power bit and never enter the queue.
    assign cmd_wr = i_wr & ~i_wdata[30];
    assign q_full = (occ == OCC_W'(FIFO_DEPTH));
    assign pop    = (state == S_IDLE) && (occ != '0);
    // A pop on the same edge frees a slot, so a full queue can still accept.
    assign push   = cmd_wr && (!q_full || pop);
    assign drop   = cmd_wr && q_full && !pop;
    assign head   = mem[rd_ptr];

    always_comb begin
        occ_next = occ;
        if (push && !pop) begin
            occ_next = occ + OCC_W'(1);
        end else if (pop && !push) begin
            occ_next = occ - OCC_W'(1);
        end
    end

    // True when the FSM will sit in IDLE after this edge; drives o_busy.
    assign fsm_idle_next = ((state == S_IDLE) && !pop) ||
                           ((state == S_EXEC) && (cnt == '0));

    // Clear display and return home need the long execution wait.
    assign is_long   = !o_lcd_rs && (o_lcd_data inside {8'h01, 8'h02, 8'h03});
    assign exec_load = is_long ? CNT_W'(T_EXEC_LONG - 1) : CNT_W'(T_EXEC - 1);

    // Queue storage carries no reset; occupancy decides what is valid.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= {i_wdata[9], i_wdata[7:0]};
        end
    end

    // Queue pointers and occupancy; pointers wrap naturally at a power of 2.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ    <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ <= occ_next;
        end
    end

    // Status flags and the power/backlight bit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_lcd_on   <= 1'b0;
            o_overflow <= 1'b0;
            o_full     <= 1'b0;
            o_busy     <= 1'b0;
        end else begin
            if (i_wr) begin
                o_lcd_on <= i_wdata[31];
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_clr_ovf) begin
                o_overflow <= 1'b0;
            end
            o_full <= (occ_next == OCC_W'(FIFO_DEPTH));
            o_busy <= (occ_next != '0) || !fsm_idle_next;
        end
    end

    // Bus sequencer: one shared down-counter times every phase.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            o_lcd_en   <= 1'b0;
            o_lcd_rs   <= 1'b0;
            o_lcd_data <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    o_lcd_en <= 1'b0;
                    if (pop) begin
                        o_lcd_rs   <= head[8];
                        o_lcd_data <= head[7:0];
                        cnt        <= CNT_W'(T_SETUP - 1);
                        state      <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        cnt      <= CNT_W'(T_PULSE - 1);
                        o_lcd_en <= 1'b1;
                        state    <= S_PULSE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_PULSE: begin
                    if (cnt == '0) begin
                        cnt      <= CNT_W'(T_HOLD - 1);
                        o_lcd_en <= 1'b0;
                        state    <= S_HOLD;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        cnt   <= exec_load;
                        state <= S_EXEC;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                S_EXEC: begin
                    if (cnt == '0) begin
                        state <= S_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    o_lcd_en <= 1'b0;
                    cnt      <= '0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_write_sequencer.sv
module tb_lcd_write_sequencer;

    localparam int DEPTH = 4;
    localparam int TS    = 2;
    localparam int TP    = 4;
    localparam int TH    = 2;
    localparam int TE    = 10;
    localparam int TEL   = 40;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic        clr = 1'b0;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on;
    logic        o_busy, o_full, o_overflow;

    lcd_write_sequencer #(
        .FIFO_DEPTH (DEPTH),
        .T_SETUP    (TS),
        .T_PULSE    (TP),
        .T_HOLD     (TH),
        .T_EXEC     (TE),
        .T_EXEC_LONG(TEL)
    ) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr      (wr),
        .i_wdata   (wdata),
        .i_clr_ovf (clr),
        .o_lcd_data(o_lcd_data),
        .o_lcd_rs  (o_lcd_rs),
        .o_lcd_rw  (o_lcd_rw),
        .o_lcd_en  (o_lcd_en),
        .o_lcd_on  (o_lcd_on),
        .o_busy    (o_busy),
        .o_full    (o_full),
        .o_overflow(o_overflow)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: every accepted command with the edge numbers at which
    // it was pushed, popped and at which the sequencer is idle again.
    typedef struct {
        int         push;
        int         pop;
        int         idle;
        bit         rs;
        logic [7:0] data;
    } ent_t;
    ent_t q[$];
    bit   m_ovf  = 1'b0;
    bit   m_on   = 1'b0;
    bit   m_busy = 1'b0;

    // EN pulse monitor
    int         pulses = 0;
    logic [7:0] pd[$];
    always @(posedge o_lcd_en) begin
        pulses++;
        pd.push_back(o_lcd_data);
    end

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s @edge %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    function automatic int exec_of(bit rs, logic [7:0] d);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? TEL : TE;
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf  = 1'b0;
        m_on   = 1'b0;
        m_busy = 1'b0;
    endtask

    task automatic model_edge(bit w, logic [31:0] d, bit c);
        int e    = cyc;
        bit drop = 1'b0;
        if (w) begin
            m_on = d[31];
            if (!d[30]) begin
                int   occ    = 0;
                bit   popnow = 1'b0;
                ent_t n;
                foreach (q[i]) begin
                    if (q[i].push < e && q[i].pop >= e) occ++;
                    if (q[i].pop == e) popnow = 1'b1;
                end
                if (occ < DEPTH || popnow) begin
                    n.push = e;
                    n.rs   = d[9];
                    n.data = d[7:0];
                    if (q.size() == 0 || q[$].idle + 1 <= e + 1) n.pop = e + 1;
                    else n.pop = q[$].idle + 1;
                    n.idle = n.pop + TS + TP + TH + exec_of(n.rs, n.data);
                    q.push_back(n);
                end else begin
                    drop = 1'b1;
                end
            end
        end
        if (drop) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
    endtask

    task automatic model_check();
        int         e      = cyc;
        bit         en     = 1'b0;
        bit         busy   = 1'b0;
        int         pend   = 0;
        int         lastp  = -1;
        bit         rs     = 1'b0;
        logic [7:0] data   = 8'h00;
        foreach (q[i]) begin
            if (q[i].pop + TS <= e && e < q[i].pop + TS + TP) en = 1'b1;
            if (q[i].pop <= e && q[i].pop > lastp) begin
                lastp = q[i].pop;
                rs    = q[i].rs;
                data  = q[i].data;
            end
            if (q[i].push <= e && q[i].idle > e) busy = 1'b1;
            if (q[i].push <= e && q[i].pop > e) pend++;
        end
        m_busy = busy;
        chk("en",   32'(o_lcd_en),   32'(en));
        chk("rs",   32'(o_lcd_rs),   32'(rs));
        chk("data", 32'(o_lcd_data), 32'(data));
        chk("rw",   32'(o_lcd_rw),   32'd0);
        chk("on",   32'(o_lcd_on),   32'(m_on));
        chk("busy", 32'(o_busy),     32'(busy));
        chk("full", 32'(o_full),     32'(pend == DEPTH));
        chk("ovf",  32'(o_overflow), 32'(m_ovf));
    endtask

    task automatic tick(bit w, logic [31:0] d, bit c);
        wr    = w;
        wdata = d;
        clr   = c;
        @(posedge clk);
        cyc++;
        model_edge(w, d, c);
        #1;
        model_check();
        wr  = 1'b0;
        clr = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (m_busy && n < 500) begin
            tick(1'b0, 32'h0, 1'b0);
            n++;
        end
        if (n >= 500) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    task automatic chk_all_zero(string tag);
        chk({tag, "_data"}, 32'(o_lcd_data), 32'd0);
        chk({tag, "_rs"},   32'(o_lcd_rs),   32'd0);
        chk({tag, "_rw"},   32'(o_lcd_rw),   32'd0);
        chk({tag, "_en"},   32'(o_lcd_en),   32'd0);
        chk({tag, "_on"},   32'(o_lcd_on),   32'd0);
        chk({tag, "_busy"}, 32'(o_busy),     32'd0);
        chk({tag, "_full"}, 32'(o_full),     32'd0);
        chk({tag, "_ovf"},  32'(o_overflow), 32'd0);
    endtask

    typedef struct {
        bit          w;
        logic [31:0] d;
        bit          en;
        bit          rs;
        logic [7:0]  data;
        bit          busy;
        bit          on;
    } vec_t;
    vec_t tv[21];

    initial begin
        int k, e0, p0;

        // Single write 0x8000_0241, one row per edge starting at the write.
        tv[0] = '{1'b1, 32'h8000_0241, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        for (int i = 1; i <= 2; i++)  tv[i] = '{1'b0, 32'h0, 1'b0, 1'b1, 8'h41, 1'b1, 1'b1};
        for (int i = 3; i <= 6; i++)  tv[i] = '{1'b0, 32'h0, 1'b1, 1'b1, 8'h41, 1'b1, 1'b1};
        for (int i = 7; i <= 18; i++) tv[i] = '{1'b0, 32'h0, 1'b0, 1'b1, 8'h41, 1'b1, 1'b1};
        for (int i = 19; i <= 20; i++) tv[i] = '{1'b0, 32'h0, 1'b0, 1'b1, 8'h41, 1'b0, 1'b1};

        // Power-on reset
        #2;
        chk_all_zero("por");
        #10 rst_n = 1'b1;
        model_reset();

        // Case 1: table-driven single command
        for (int i = 0; i < 21; i++) begin
            tick(tv[i].w, tv[i].d, 1'b0);
            chk($sformatf("tv%0d_en", i),   32'(o_lcd_en),   32'(tv[i].en));
            chk($sformatf("tv%0d_rs", i),   32'(o_lcd_rs),   32'(tv[i].rs));
            chk($sformatf("tv%0d_data", i), 32'(o_lcd_data), 32'(tv[i].data));
            chk($sformatf("tv%0d_busy", i), 32'(o_busy),     32'(tv[i].busy));
            chk($sformatf("tv%0d_on", i),   32'(o_lcd_on),   32'(tv[i].on));
        end

        // Case 2: clear display gets the long exec wait before the next command
        drain();
        tick(1'b1, 32'h8000_0001, 1'b0);
        k = cyc;
        tick(1'b1, 32'h8000_0255, 1'b0);
        while (cyc < k + 49) tick(1'b0, 32'h0, 1'b0);
        chk("clr_hold_data", 32'(o_lcd_data), 32'h01);
        tick(1'b0, 32'h0, 1'b0);
        chk("clr_next_data", 32'(o_lcd_data), 32'h55);
        chk("clr_next_rs",   32'(o_lcd_rs),   32'd1);

        // Case 3: six back-to-back writes, the sixth is dropped
        drain();
        p0 = pulses;
        for (int i = 0; i < 6; i++) tick(1'b1, 32'h8000_0261 + 32'(i), 1'b0);
        chk("burst_full", 32'(o_full),     32'd1);
        chk("burst_ovf",  32'(o_overflow), 32'd1);
        drain();
        chk("burst_pulses", 32'(pulses - p0), 32'd5);
        for (int i = 0; i < 5; i++)
            if (p0 + i < pd.size()) chk($sformatf("burst_order%0d", i), 32'(pd[p0 + i]), 32'h61 + 32'(i));
        chk("burst_ovf_sticky", 32'(o_overflow), 32'd1);
        tick(1'b0, 32'h0, 1'b1);
        chk("burst_ovf_clr", 32'(o_overflow), 32'd0);

        // Case 4: CTRL_ONLY power-off during PULSE
        drain();
        p0 = pulses;
        tick(1'b1, 32'h8000_0248, 1'b0);
        for (int i = 0; i < 4; i++) tick(1'b0, 32'h0, 1'b0);
        tick(1'b1, 32'h4000_0000, 1'b0);
        chk("ctrl_on",  32'(o_lcd_on), 32'd0);
        chk("ctrl_en",  32'(o_lcd_en), 32'd1);
        drain();
        chk("ctrl_pulses", 32'(pulses - p0), 32'd1);

        // Case 5: asynchronous reset in the middle of a pulse
        p0 = pulses;
        tick(1'b1, 32'h8000_024A, 1'b0);
        for (int i = 0; i < 3; i++) tick(1'b0, 32'h0, 1'b0);
        chk("pre_rst_en", 32'(o_lcd_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(posedge clk);
        #1;
        chk_all_zero("arst_hold");
        #3 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 30; i++) tick(1'b0, 32'h0, 1'b0);
        chk("post_rst_pulses", 32'(pulses - p0), 32'd1);

        // Case 6: full queue, push and pop on the same edge
        drain();
        e0 = cyc + 1;
        for (int i = 0; i < 5; i++) tick(1'b1, 32'h8000_0270 + 32'(i), 1'b0);
        while (cyc < e0 + 19) tick(1'b0, 32'h0, 1'b0);
        chk("pp_full_before", 32'(o_full), 32'd1);
        tick(1'b1, 32'h8000_0275, 1'b0);
        chk("pp_ovf",  32'(o_overflow), 32'd0);
        chk("pp_full", 32'(o_full),     32'd1);
        chk("pp_data", 32'(o_lcd_data), 32'h71);
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] d;
            bit          w;
            bit          c;
            w = ($urandom_range(0, 5) == 0);
            c = ($urandom_range(0, 19) == 0);
            d = $urandom;
            d[30] = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 4) == 0) begin
                d[9]   = 1'b0;
                d[7:0] = 8'($urandom_range(1, 3));
            end
            tick(w, d, c);
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
